// File: rtl/ahbl_cmd_master_if.sv
// Command/response stream and AHB-Lite master bus bundle for ahbl_cmd_master.
// The master modport is the bus-master block; the slave modport is its environment.
interface ahbl_cmd_master_if;
   logic        cmd_valid_i;
   logic        cmd_ready_o;
   logic        cmd_write_i;
   logic        cmd_poll_i;
   logic [31:0] cmd_addr_i;
   logic [31:0] cmd_wdata_i;
   logic [31:0] cmd_mask_i;

   logic        rsp_valid_o;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic        rsp_timeout_o;

   logic [31:0] ahb_m0_haddr_o;
   logic        ahb_m0_hwrite_o;
   logic [2:0]  ahb_m0_hsize_o;
   logic [2:0]  ahb_m0_hburst_o;
   logic [3:0]  ahb_m0_hprot_o;
   logic [1:0]  ahb_m0_htrans_o;
   logic        ahb_m0_hmastlock_o;
   logic [31:0] ahb_m0_hwdata_o;
   logic        ahb_m0_hready_i;
   logic        ahb_m0_hresp_i;
   logic [31:0] ahb_m0_hrdata_i;

   modport master (
      input  cmd_valid_i, cmd_write_i, cmd_poll_i, cmd_addr_i, cmd_wdata_i, cmd_mask_i,
      output cmd_ready_o,
      output rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
      output ahb_m0_haddr_o, ahb_m0_hwrite_o, ahb_m0_hsize_o, ahb_m0_hburst_o,
      output ahb_m0_hprot_o, ahb_m0_htrans_o, ahb_m0_hmastlock_o, ahb_m0_hwdata_o,
      input  ahb_m0_hready_i, ahb_m0_hresp_i, ahb_m0_hrdata_i
   );

   modport slave (
      output cmd_valid_i, cmd_write_i, cmd_poll_i, cmd_addr_i, cmd_wdata_i, cmd_mask_i,
      input  cmd_ready_o,
      input  rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
      input  ahb_m0_haddr_o, ahb_m0_hwrite_o, ahb_m0_hsize_o, ahb_m0_hburst_o,
      input  ahb_m0_hprot_o, ahb_m0_htrans_o, ahb_m0_hmastlock_o, ahb_m0_hwdata_o,
      output ahb_m0_hready_i, ahb_m0_hresp_i, ahb_m0_hrdata_i
   );
endinterface

// File: rtl/ahbl_cmd_master.sv
// AHB-Lite single-transfer master: one command -> one word read/write, or a
// hardware poll loop that re-reads until (rdata & mask) == (wdata & mask).
module ahbl_cmd_master #(
   parameter int POLL_MAX = 1024,
   parameter int POLL_GAP = 4
) (
   input  logic               clk,
   input  logic               resetn,
   ahbl_cmd_master_if.master  bus
);
   localparam int AW = $clog2(POLL_MAX + 1);
   localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
   localparam logic [1:0] HT_IDLE   = 2'b00;
   localparam logic [1:0] HT_NONSEQ = 2'b10;

   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_GAP, S_RESP} state_t;

   state_t        r_state;
   state_t        w_next;
   logic          r_ready;
   logic [31:0]   r_addr;
   logic          r_write;
   logic          r_poll;
   logic [31:0]   r_wdata;
   logic [31:0]   r_mask;
   logic [31:0]   r_rdata;
   logic          r_err;
   logic          r_timeout;
   logic [AW-1:0] r_attempts;
   logic [GW-1:0] r_gap_cnt;

   logic          w_accept;
   logic          w_match;
   logic          w_last;
   logic          w_gap_end;
   logic          w_data_done;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // r_ready is only ever set while the FSM sits in IDLE, so it doubles as the accept qualifier
   always_comb begin
      w_accept    = bus.cmd_valid_i && r_ready;
      w_match     = ((bus.ahb_m0_hrdata_i ^ r_wdata) & r_mask) == 32'h0;
      w_last      = (r_attempts == AW'(POLL_MAX));
      w_gap_end   = (POLL_GAP == 0) || (r_gap_cnt == GW'(POLL_GAP - 1));
      w_data_done = (r_state == S_DATA) && bus.ahb_m0_hready_i;
      w_next      = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_next = S_ADDR;
         S_ADDR: if (bus.ahb_m0_hready_i) w_next = S_DATA;
         S_DATA: begin
            if (bus.ahb_m0_hready_i) begin
               if (bus.ahb_m0_hresp_i || !r_poll || w_match || w_last) w_next = S_RESP;
               else if (POLL_GAP == 0)                                   w_next = S_ADDR;
               else                                                      w_next = S_GAP;
            end
         end
         S_GAP:  if (w_gap_end) w_next = S_ADDR;
         S_RESP: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_ready    <= 1'b0;
         r_addr     <= 32'h0;
         r_write    <= 1'b0;
         r_poll     <= 1'b0;
         r_wdata    <= 32'h0;
         r_mask     <= 32'h0;
         r_rdata    <= 32'h0;
         r_err      <= 1'b0;
         r_timeout  <= 1'b0;
         r_attempts <= '0;
         r_gap_cnt  <= '0;
      end else begin
         r_ready <= (w_next == S_IDLE);
         if (w_accept) begin
            r_addr     <= bus.cmd_addr_i & ~32'h3;
            r_write    <= bus.cmd_write_i;
            r_poll     <= bus.cmd_poll_i & ~bus.cmd_write_i;
            r_wdata    <= bus.cmd_wdata_i;
            r_mask     <= bus.cmd_mask_i;
            r_err      <= 1'b0;
            r_timeout  <= 1'b0;
            r_attempts <= AW'(1);
         end
         if (w_data_done) begin
            if (bus.ahb_m0_hresp_i) r_err <= 1'b1;
            else if (!r_write)      r_rdata <= bus.ahb_m0_hrdata_i;
            if (!bus.ahb_m0_hresp_i && r_poll && !w_match && w_last) r_timeout <= 1'b1;
         end
         // a re-entry into ADDR from DATA/GAP is a new poll attempt
         if ((r_state == S_DATA || r_state == S_GAP) && w_next == S_ADDR && !w_last)
            r_attempts <= r_attempts + AW'(1);
         if (r_state == S_GAP) r_gap_cnt <= r_gap_cnt + GW'(1);
         else                  r_gap_cnt <= '0;
      end
   end

   assign bus.cmd_ready_o        = r_ready;
   assign bus.rsp_valid_o        = (r_state == S_RESP);
   assign bus.rsp_rdata_o        = r_rdata;
   assign bus.rsp_err_o          = r_err;
   assign bus.rsp_timeout_o      = r_timeout;
   assign bus.ahb_m0_haddr_o     = r_addr;
   assign bus.ahb_m0_hwrite_o    = r_write;
   assign bus.ahb_m0_hsize_o     = 3'b010;
   assign bus.ahb_m0_hburst_o    = 3'b000;
   assign bus.ahb_m0_hprot_o     = 4'b0011;
   assign bus.ahb_m0_htrans_o    = (r_state == S_ADDR) ? HT_NONSEQ : HT_IDLE;
   assign bus.ahb_m0_hmastlock_o = 1'b0;
   assign bus.ahb_m0_hwdata_o    = r_write ? r_wdata : 32'h0;
endmodule

// File: tb/tb_ahbl_cmd_master.sv
// Directed bench for ahbl_cmd_master: write, wait-stated read, poll match,
// poll timeout, slave ERROR and mid-transfer reset.
module tb_ahbl_cmd_master;
   logic        clk = 1'b0;
   logic        resetn;
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          ns_cnt = 0;
   int          rv_cnt = 0;
   int          stamp [64];
   int          ns_base = 0;
   int          match_at = 0;
   logic [31:0] sl_rdata = 32'h0;

   always #5 clk = ~clk;

   ahbl_cmd_master_if bus();

   ahbl_cmd_master #(.POLL_MAX(8), .POLL_GAP(4)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always @(posedge clk) cyc++;

   // accepted address phases and response pulses, sampled mid-cycle
   always @(negedge clk) begin
      if (bus.ahb_m0_htrans_o == 2'b10 && bus.ahb_m0_hready_i) begin
         stamp[ns_cnt % 64] = cyc;
         ns_cnt++;
      end
      if (bus.rsp_valid_o) rv_cnt++;
   end

   // slave read data: when match_at>0 the Nth attempt of a poll returns 1
   assign bus.ahb_m0_hrdata_i = (match_at > 0) ?
                                (((ns_cnt - ns_base) >= match_at) ? 32'h1 : 32'h0) : sl_rdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic wr, input logic pl, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] mk);
      chk("ready_before_issue", bus.cmd_ready_o, 1);
      bus.cmd_valid_i = 1'b1;
      bus.cmd_write_i = wr;
      bus.cmd_poll_i  = pl;
      bus.cmd_addr_i  = addr;
      bus.cmd_wdata_i = wd;
      bus.cmd_mask_i  = mk;
      tick();
      bus.cmd_valid_i = 1'b0;
      bus.cmd_addr_i  = 32'hFFFF_FFFF;
      bus.cmd_wdata_i = 32'hFFFF_FFFF;
      bus.cmd_mask_i  = 32'h0;
   endtask

   task automatic wait_rsp(input int budget);
      int n;
      n = 0;
      while (!bus.rsp_valid_o && n < budget) begin
         tick();
         n++;
      end
      chk("rsp_within_budget", bus.rsp_valid_o, 1);
   endtask

   initial begin
      int b;
      int rvb;
      resetn              = 1'b0;
      bus.cmd_valid_i     = 1'b0;
      bus.cmd_write_i     = 1'b0;
      bus.cmd_poll_i      = 1'b0;
      bus.cmd_addr_i      = 32'h0;
      bus.cmd_wdata_i     = 32'h0;
      bus.cmd_mask_i      = 32'h0;
      bus.ahb_m0_hready_i = 1'b1;
      bus.ahb_m0_hresp_i  = 1'b0;
      #2;
      chk("rst_ready", bus.cmd_ready_o, 0);
      chk("rst_rsp_valid", bus.rsp_valid_o, 0);
      chk("rst_htrans", bus.ahb_m0_htrans_o, 0);
      chk("rst_haddr", bus.ahb_m0_haddr_o, 0);
      chk("rst_hsize", bus.ahb_m0_hsize_o, 3'b010);
      chk("rst_hburst", bus.ahb_m0_hburst_o, 0);
      chk("rst_hprot", bus.ahb_m0_hprot_o, 4'b0011);
      chk("rst_hmastlock", bus.ahb_m0_hmastlock_o, 0);
      @(negedge clk);
      resetn = 1'b1;
      tick();
      chk("ready_after_reset", bus.cmd_ready_o, 1);

      // zero-wait write
      issue(1'b1, 1'b0, 32'h4000_000C, 32'h0000_0A5C, 32'h0);
      chk("wr_htrans_nonseq", bus.ahb_m0_htrans_o, 2'b10);
      chk("wr_haddr", bus.ahb_m0_haddr_o, 32'h4000_000C);
      chk("wr_hwrite", bus.ahb_m0_hwrite_o, 1);
      chk("wr_ready_busy", bus.cmd_ready_o, 0);
      tick();
      chk("wr_data_htrans_idle", bus.ahb_m0_htrans_o, 2'b00);
      chk("wr_hwdata", bus.ahb_m0_hwdata_o, 32'h0000_0A5C);
      chk("wr_haddr_hold", bus.ahb_m0_haddr_o, 32'h4000_000C);
      chk("wr_rsp_not_yet", bus.rsp_valid_o, 0);
      tick();
      chk("wr_rsp_valid", bus.rsp_valid_o, 1);
      chk("wr_rsp_err", bus.rsp_err_o, 0);
      tick();
      chk("wr_rsp_pulse_end", bus.rsp_valid_o, 0);
      chk("wr_ready_again", bus.cmd_ready_o, 1);

      // read with two data-phase wait states; address bits [1:0] dropped
      sl_rdata = 32'h0;
      issue(1'b0, 1'b0, 32'h4008_0007, 32'h0, 32'h0);
      chk("rd_haddr_aligned", bus.ahb_m0_haddr_o, 32'h4008_0004);
      chk("rd_hwrite", bus.ahb_m0_hwrite_o, 0);
      tick();
      bus.ahb_m0_hready_i = 1'b0;
      tick();
      chk("rd_wait_no_rsp", bus.rsp_valid_o, 0);
      tick();
      chk("rd_wait2_no_rsp", bus.rsp_valid_o, 0);
      bus.ahb_m0_hready_i = 1'b1;
      sl_rdata = 32'h0000_0001;
      tick();
      chk("rd_rsp_valid", bus.rsp_valid_o, 1);
      chk("rd_rdata", bus.rsp_rdata_o, 32'h0000_0001);
      sl_rdata = 32'h0;
      tick();
      chk("rd_rdata_holds", bus.rsp_rdata_o, 32'h0000_0001);

      // poll: match on the third attempt, attempts 6 cycles apart
      ns_base  = ns_cnt;
      match_at = 3;
      issue(1'b0, 1'b1, 32'h4008_0004, 32'h1, 32'h1);
      wait_rsp(100);
      b = ns_base;
      chk("poll_attempts", ns_cnt - ns_base, 3);
      chk("poll_gap_1_2", stamp[(b + 1) % 64] - stamp[b % 64], 6);
      chk("poll_gap_2_3", stamp[(b + 2) % 64] - stamp[(b + 1) % 64], 6);
      chk("poll_rdata", bus.rsp_rdata_o, 32'h1);
      chk("poll_timeout", bus.rsp_timeout_o, 0);
      chk("poll_err", bus.rsp_err_o, 0);
      match_at = 0;
      tick();

      // poll that never matches: POLL_MAX=8 attempts then timeout
      ns_base  = ns_cnt;
      sl_rdata = 32'hFFFF_FFFE;
      issue(1'b0, 1'b1, 32'h4008_0004, 32'h1, 32'h1);
      wait_rsp(200);
      chk("to_attempts", ns_cnt - ns_base, 8);
      chk("to_timeout", bus.rsp_timeout_o, 1);
      chk("to_err", bus.rsp_err_o, 0);
      chk("to_rdata", bus.rsp_rdata_o, 32'hFFFF_FFFE);
      tick();
      sl_rdata = 32'h0;

      // two-cycle ERROR response on a write
      ns_base = ns_cnt;
      issue(1'b1, 1'b0, 32'h4000_0010, 32'h0000_0055, 32'h0);
      chk("err_timeout_cleared", bus.rsp_timeout_o, 0);
      tick();
      bus.ahb_m0_hready_i = 1'b0;
      bus.ahb_m0_hresp_i  = 1'b1;
      tick();
      chk("err_first_cycle_no_rsp", bus.rsp_valid_o, 0);
      bus.ahb_m0_hready_i = 1'b1;
      tick();
      chk("err_rsp_valid", bus.rsp_valid_o, 1);
      chk("err_flag", bus.rsp_err_o, 1);
      chk("err_no_timeout", bus.rsp_timeout_o, 0);
      chk("err_no_retry", ns_cnt - ns_base, 1);
      bus.ahb_m0_hresp_i = 1'b0;
      tick();
      chk("err_ready_after", bus.cmd_ready_o, 1);
      chk("err_rsp_pulse_end", bus.rsp_valid_o, 0);

      // reset during the data phase of a poll
      issue(1'b0, 1'b1, 32'h4008_0004, 32'h1, 32'h1);
      tick();
      chk("rstmid_in_data", bus.ahb_m0_htrans_o, 2'b00);
      rvb = rv_cnt;
      resetn = 1'b0;
      #1;
      chk("rstmid_htrans", bus.ahb_m0_htrans_o, 0);
      chk("rstmid_rsp_valid", bus.rsp_valid_o, 0);
      chk("rstmid_ready", bus.cmd_ready_o, 0);
      chk("rstmid_haddr", bus.ahb_m0_haddr_o, 0);
      chk("rstmid_rdata", bus.rsp_rdata_o, 0);
      chk("rstmid_err", bus.rsp_err_o, 0);
      chk("rstmid_hsize", bus.ahb_m0_hsize_o, 3'b010);
      repeat (3) tick();
      @(negedge clk);
      resetn = 1'b1;
      chk("rstmid_no_rsp_pulse", rv_cnt - rvb, 0);
      tick();
      sl_rdata = 32'h1234_ABCD;
      issue(1'b0, 1'b0, 32'h4000_0020, 32'h0, 32'h0);
      chk("post_rst_haddr", bus.ahb_m0_haddr_o, 32'h4000_0020);
      wait_rsp(20);
      chk("post_rst_rdata", bus.rsp_rdata_o, 32'h1234_ABCD);
      chk("post_rst_err", bus.rsp_err_o, 0);
      chk("post_rst_timeout", bus.rsp_timeout_o, 0);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
